// File: rtl/mux16_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux16_rr_arbiter_if
// Brief    : Request/data/grant bundle between 16 requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic [15:0] din;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic        switch;
    logic        y;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  busy,
        input  switch,
        input  y
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output busy,
        output switch,
        output y
    );
endinterface
`default_nettype wire

// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux16_rr_arbiter
// Brief    : Round-robin owner selection for a shared 1-bit 16:1 mux datapath.
// Revision : 1.0 - initial release
// ============================================================================

module mux16_sel (
    input  wire logic [15:0] i_din,
    input  wire logic [3:0]  i_sel,
    output logic             o_y
);
    assign o_y = i_din[i_sel];
endmodule

module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux16_rr_arbiter_if.slave bus
);
    localparam int c_hw = $clog2(MAX_HOLD + 1);
    localparam logic [c_hw-1:0] c_hold_max  = c_hw'(MAX_HOLD);
    localparam logic [c_hw-1:0] c_hold_last = c_hw'(MAX_HOLD - 1);
    localparam logic [c_hw-1:0] c_hcnt_one  = c_hw'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state, w_state;
    logic [3:0]      r_ptr, w_ptr;
    logic [c_hw-1:0] r_hcnt, w_hcnt;
    logic [15:0]     r_gnt, w_gnt;
    logic [3:0]      r_sel, w_sel;
    logic            r_busy, w_busy;
    logic            r_switch, w_switch;

    logic [15:0]     w_others;
    logic [4:0]      w_pick_all;
    logic [4:0]      w_pick_oth;
    logic            w_release;
    logic            w_rotate;
    logic            w_grant;
    logic [3:0]      w_owner;
    logic            w_y;

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] mask, input logic [3:0] start);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int k = 15; k >= 0; k--) begin
            idx = start + 4'(k);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        w_others   = bus.req & ~r_gnt;
        w_pick_all = rr_pick(bus.req, r_ptr);
        w_pick_oth = rr_pick(w_others, r_ptr);
        w_release  = !bus.req[r_sel];
        // A saturated (previously uncontended) owner yields as soon as a competitor appears.
        w_rotate   = (r_hcnt >= c_hold_last) && (|w_others);

        w_state  = r_state;
        w_ptr    = r_ptr;
        w_hcnt   = r_hcnt;
        w_gnt    = r_gnt;
        w_sel    = r_sel;
        w_busy   = r_busy;
        w_switch = 1'b0;
        w_grant  = 1'b0;
        w_owner  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_all[4]) begin
                    w_grant = 1'b1;
                    w_owner = w_pick_all[3:0];
                end
            end
            ST_GRANT: begin
                if (w_release || w_rotate) begin
                    if (w_pick_oth[4]) begin
                        w_grant = 1'b1;
                        w_owner = w_pick_oth[3:0];
                    end else begin
                        w_state = ST_IDLE;
                        w_gnt   = '0;
                        w_busy  = 1'b0;
                    end
                end else if (r_hcnt != c_hold_max) begin
                    w_hcnt = r_hcnt + c_hcnt_one;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = '0;
                w_busy  = 1'b0;
            end
        endcase

        if (w_grant) begin
            w_state  = ST_GRANT;
            w_gnt    = 16'd1 << w_owner;
            w_sel    = w_owner;
            w_busy   = 1'b1;
            w_switch = 1'b1;
            w_ptr    = w_owner + 4'd1;
            w_hcnt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_hcnt   <= '0;
            r_gnt    <= '0;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ptr    <= w_ptr;
            r_hcnt   <= w_hcnt;
            r_gnt    <= w_gnt;
            r_sel    <= w_sel;
            r_busy   <= w_busy;
            r_switch <= w_switch;
        end
    end

    mux16_sel u_mux (
        .i_din (bus.din),
        .i_sel (r_sel),
        .o_y   (w_y)
    );

    assign bus.gnt    = r_gnt;
    assign bus.sel    = r_sel;
    assign bus.busy   = r_busy;
    assign bus.switch = r_switch;
    assign bus.y      = w_y;
endmodule
`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux16_rr_arbiter
// Brief    : Directed and random checks of mux16_rr_arbiter at several hold limits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux16_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] din;

    logic [15:0] gnt_o  [4];
    logic [3:0]  sel_o  [4];
    logic        busy_o [4];
    logic        sw_o   [4];
    logic        y_o    [4];

    int n_vec = 0;
    int n_bad = 0;

    int m_own  [4];
    int m_ptr  [4];
    int m_hcnt [4];
    bit m_busy [4];
    bit m_sw   [4];
    int wcnt   [4][16];
    int wmax   [4];

    int exp_sel [8] = '{0, 1, 1, 15, 15, 0, 0, 1};
    int exp_sw  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    always #5 clk = ~clk;

    function automatic int mh_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 8 : (d == 2) ? 1 : 3;
    endfunction

    for (genvar d = 0; d < 4; d++) begin : g_dut
        mux16_rr_arbiter_if u_if ();
        assign u_if.req = req;
        assign u_if.din = din;
        mux16_rr_arbiter #(.MAX_HOLD(mh_of(d))) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );
        assign gnt_o[d]  = u_if.gnt;
        assign sel_o[d]  = u_if.sel;
        assign busy_o[d] = u_if.busy;
        assign sw_o[d]   = u_if.switch;
        assign y_o[d]    = u_if.y;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_next(input logic [15:0] m, input int p);
        int res;
        bit found;
        res   = -1;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!found && m[(p + k) % 16]) begin
                found = 1'b1;
                res   = (p + k) % 16;
            end
        end
        return res;
    endfunction

    task automatic model_reset(input int d);
        m_own[d]  = 0;
        m_ptr[d]  = 0;
        m_hcnt[d] = 0;
        m_busy[d] = 1'b0;
        m_sw[d]   = 1'b0;
    endtask

    // Predicts the state after the next rising edge from the inputs held now.
    task automatic model_step(input int d);
        logic [15:0] oth;
        int c;
        m_sw[d] = 1'b0;
        oth = req;
        c = -1;
        if (!m_busy[d]) begin
            c = rr_next(req, m_ptr[d]);
        end else begin
            oth[m_own[d]] = 1'b0;
            if (!req[m_own[d]] || (m_hcnt[d] >= mh_of(d) - 1 && oth != 16'd0)) begin
                c = rr_next(oth, m_ptr[d]);
                if (c < 0) m_busy[d] = 1'b0;
            end else if (m_hcnt[d] < mh_of(d)) begin
                m_hcnt[d] = m_hcnt[d] + 1;
            end
        end
        if (c >= 0) begin
            m_own[d]  = c;
            m_busy[d] = 1'b1;
            m_sw[d]   = 1'b1;
            m_hcnt[d] = 0;
            m_ptr[d]  = (c + 1) % 16;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (!rst_n) model_reset(d);
            check_eq($sformatf("model_gnt%0d", d), 32'(gnt_o[d]),
                     m_busy[d] ? (32'd1 << m_own[d]) : 32'd0);
            check_eq($sformatf("model_busy%0d", d), 32'(busy_o[d]), 32'(m_busy[d]));
            check_eq($sformatf("model_switch%0d", d), 32'(sw_o[d]), 32'(m_sw[d]));
            if (m_busy[d]) begin
                check_eq($sformatf("model_sel%0d", d), 32'(sel_o[d]), 32'(m_own[d]));
                check_eq($sformatf("model_y%0d", d), 32'(y_o[d]), 32'(din[m_own[d]]));
            end else if (!rst_n) begin
                check_eq($sformatf("model_y_rst%0d", d), 32'(y_o[d]), 32'(din[0]));
            end
            for (int i = 0; i < 16; i++) begin
                if (rst_n && req[i] && !gnt_o[d][i]) wcnt[d][i] = wcnt[d][i] + 1;
                else                                 wcnt[d][i] = 0;
                if (wcnt[d][i] > wmax[d]) wmax[d] = wcnt[d][i];
            end
            if (rst_n) model_step(d);
        end
    end

    initial begin
        int nsw;
        int nbadg;
        rst_n = 1'b0;
        req   = 16'h0000;
        din   = 16'hA5A5;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check_eq($sformatf("rst_gnt%0d", d), 32'(gnt_o[d]), 32'h0);
            check_eq($sformatf("rst_sel%0d", d), 32'(sel_o[d]), 32'h0);
            check_eq($sformatf("rst_busy%0d", d), 32'(busy_o[d]), 32'h0);
            check_eq($sformatf("rst_switch%0d", d), 32'(sw_o[d]), 32'h0);
            check_eq($sformatf("rst_y%0d", d), 32'(y_o[d]), 32'h1);
        end
        din = 16'hA5A4;
        #1;
        check_eq("rst_y_follow", 32'(y_o[1]), 32'h0);

        // Single request after reset
        rst_n = 1'b1;
        req   = 16'h0010;
        din   = 16'h0010;
        tick();
        check_eq("single_gnt", 32'(gnt_o[1]), 32'h0010);
        check_eq("single_sel", 32'(sel_o[1]), 32'd4);
        check_eq("single_busy", 32'(busy_o[1]), 32'h1);
        check_eq("single_switch", 32'(sw_o[1]), 32'h1);
        check_eq("single_y_hi", 32'(y_o[1]), 32'h1);
        din = 16'hFFEF;
        #1;
        check_eq("single_y_lo", 32'(y_o[1]), 32'h0);
        tick();
        check_eq("single_switch_end", 32'(sw_o[1]), 32'h0);
        check_eq("single_gnt_hold", 32'(gnt_o[1]), 32'h0010);
        req = 16'h0000;
        tick();
        check_eq("drop_gnt", 32'(gnt_o[1]), 32'h0);
        check_eq("drop_busy", 32'(busy_o[1]), 32'h0);

        // Direct handoff from owner 3 to owner 8
        req = 16'h0008;
        tick();
        check_eq("hand_gnt3", 32'(gnt_o[1]), 32'h0008);
        req = 16'h0108;
        tick();
        check_eq("hand_hold3", 32'(gnt_o[1]), 32'h0008);
        req = 16'h0100;
        tick();
        check_eq("hand_gnt8", 32'(gnt_o[1]), 32'h0100);
        check_eq("hand_switch", 32'(sw_o[1]), 32'h1);
        check_eq("hand_busy", 32'(busy_o[1]), 32'h1);
        tick();
        check_eq("hand_switch_end", 32'(sw_o[1]), 32'h0);
        req = 16'h0000;
        tick();
        check_eq("hand_idle", 32'(busy_o[1]), 32'h0);

        // Uncontended hold, then a late competitor must still get a turn
        req   = 16'h0004;
        nsw   = 0;
        nbadg = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            nsw = nsw + int'(sw_o[1]);
            if (gnt_o[1] != 16'h0004) nbadg++;
        end
        check_eq("uncont_switches", 32'(nsw), 32'd1);
        check_eq("uncont_gnt_errs", 32'(nbadg), 32'd0);
        req = 16'h0044;
        tick();
        check_eq("late_comp_gnt", 32'(gnt_o[1]), 32'h0040);
        check_eq("late_comp_switch", 32'(sw_o[1]), 32'h1);

        // Async reset while owner is 9
        req = 16'h0200;
        tick();
        check_eq("own9_gnt", 32'(gnt_o[1]), 32'h0200);
        check_eq("own9_sel", 32'(sel_o[1]), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt", 32'(gnt_o[1]), 32'h0);
        check_eq("arst_sel", 32'(sel_o[1]), 32'h0);
        check_eq("arst_busy", 32'(busy_o[1]), 32'h0);
        check_eq("arst_switch", 32'(sw_o[1]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 16'hFFFF;
        tick();
        check_eq("arst_first_gnt", 32'(gnt_o[1]), 32'h0001);
        check_eq("arst_first_gnt_mh2", 32'(gnt_o[0]), 32'h0001);

        // Round-robin order with MAX_HOLD = 2
        req = 16'h8003;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("rr_sel[%0d]", i), 32'(sel_o[0]), 32'(exp_sel[i]));
            check_eq($sformatf("rr_switch[%0d]", i), 32'(sw_o[0]), 32'(exp_sw[i]));
            check_eq($sformatf("rr_gnt[%0d]", i), 32'(gnt_o[0]), 32'd1 << exp_sel[i]);
        end

        // Random stress
        for (int d = 0; d < 4; d++) begin
            wmax[d] = 0;
            for (int i = 0; i < 16; i++) wcnt[d][i] = 0;
        end
        for (int n = 0; n < 10000; n++) begin
            tick();
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            din = 16'($urandom);
        end
        tick();
        for (int d = 0; d < 4; d++) begin
            check_eq($sformatf("starve_bound%0d", d), 32'(wmax[d] <= 15 * mh_of(d) + 1), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
